// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 16-word block, then streams W_t for t=0..ROUNDS-1
// from a 16-word sliding window, computing W_{t+16} as each word is consumed.
module sha256_msg_schedule #(
    parameter int ROUNDS     = 64,
    parameter int LOAD_WORDS = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               msg_word,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    output logic [31:0]               wt,
    output logic [$clog2(ROUNDS)-1:0] wt_index,
    output logic                      wt_valid,
    input  logic                      wt_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int TW  = $clog2(ROUNDS);
    localparam int LCW = $clog2(LOAD_WORDS);
    localparam logic [TW-1:0]  T_LAST  = TW'(ROUNDS - 1);
    localparam logic [LCW-1:0] LC_LAST = LCW'(LOAD_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [31:0]    r_window [LOAD_WORDS];
    logic [LCW-1:0] r_load_cnt;
    logic [TW-1:0]  r_t;
    logic           r_msg_ready;
    logic           r_wt_valid;
    logic           r_busy;
    logic           r_done;

    logic [31:0]    w_next_word;
    logic           w_accept;
    logic           w_xfer;

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // window[0] is W_t, so window[14], [9], [1], [0] are W_{t+14}, W_{t+9}, W_{t+1}, W_t.
    assign w_next_word = small_sigma1(r_window[14]) + r_window[9]
                       + small_sigma0(r_window[1]) + r_window[0];
    assign w_accept    = msg_valid && r_msg_ready;
    assign w_xfer      = r_wt_valid && wt_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            // NOTE: the window is a register file, not RAM, so clearing it on reset is cheap
            // and makes wt read as zero after a mid-block abort.
            for (int i = 0; i < LOAD_WORDS; i++) r_window[i] <= '0;
            r_load_cnt  <= '0;
            r_t         <= '0;
            r_msg_ready <= 1'b0;
            r_wt_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_load_cnt  <= '0;
                        r_msg_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_window[r_load_cnt] <= msg_word;
                        r_load_cnt           <= r_load_cnt + 1'b1;
                        if (r_load_cnt == LC_LAST) begin
                            r_state     <= S_EXPAND;
                            r_t         <= '0;
                            r_msg_ready <= 1'b0;
                            r_wt_valid  <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    if (w_xfer) begin
                        for (int i = 0; i < LOAD_WORDS - 1; i++) r_window[i] <= r_window[i+1];
                        r_window[LOAD_WORDS-1] <= w_next_word;
                        r_t                    <= r_t + 1'b1;
                        if (r_t == T_LAST) begin
                            r_state    <= S_DONE;
                            r_wt_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign msg_ready = r_msg_ready;
    assign wt        = r_window[0];
    assign wt_index  = r_t;
    assign wt_valid  = r_wt_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule against a textbook array-based W_t model.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] msg_word;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] wt;
    logic [5:0]  wt_index;
    logic        wt_valid;
    logic        wt_ready;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [31:0] blk_w [16];
    logic [31:0] exp_w [ROUNDS];
    logic [31:0] obs_w [ROUNDS];

    sha256_msg_schedule #(.ROUNDS(ROUNDS), .LOAD_WORDS(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .msg_word  (msg_word),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .wt        (wt),
        .wt_index  (wt_index),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // FIPS 180-4 schedule recurrence over a plain array.
    task automatic ref_schedule();
        for (int t = 0; t < 16; t++) exp_w[t] = blk_w[t];
        for (int t = 16; t < ROUNDS; t++) begin
            exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
        blk_w[0]  = 32'h61626380;
        blk_w[15] = 32'h00000018;
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) blk_w[i] = $urandom;
    endtask

    // Runs one block from IDLE; ends back in IDLE (or right after an abort reset).
    task automatic run_block(input bit gaps, input bit bp, input bit pulse_start,
                             input bit hold_start, input int abort_at);
        int idx;
        int t;
        int cyc;
        int d0;
        bit acc;
        ref_schedule();
        d0 = done_cnt;
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        check("load_entry_busy", 32'(busy), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 500) begin
            msg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            msg_word  = msg_valid ? blk_w[idx] : $urandom;
            if (pulse_start && !hold_start) start = 1'($urandom_range(0, 1));
            check("load_msg_ready", 32'(msg_ready), 32'd1);
            check("load_no_wt_valid", 32'(wt_valid), 32'd0);
            acc = msg_valid && msg_ready;
            step();
            cyc++;
            if (acc) idx++;
        end
        if (idx < 16) check("load_timeout", 32'(idx), 32'd16);
        msg_valid = 1'b0;
        t = 0;
        cyc = 0;
        while (t < ROUNDS && cyc < 1000) begin
            if (t == abort_at) begin
                reset    = 1'b1;
                start    = 1'b0;
                wt_ready = 1'b1;
                step();
                reset = 1'b0;
                check("abort_wt_valid", 32'(wt_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_msg_ready", 32'(msg_ready), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_wt_zero", wt, 32'd0);
                check("abort_index_zero", 32'(wt_index), 32'd0);
                check("abort_no_done", 32'(done_cnt - d0), 32'd0);
                return;
            end
            check("exp_wt_valid", 32'(wt_valid), 32'd1);
            check("exp_busy", 32'(busy), 32'd1);
            check("exp_msg_ready", 32'(msg_ready), 32'd0);
            check("exp_wt_index", 32'(wt_index), 32'(t));
            check($sformatf("exp_wt[%0d]", t), wt, exp_w[t]);
            obs_w[t] = wt;
            wt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_start && !hold_start) start = 1'($urandom_range(0, 1));
            acc = wt_valid && wt_ready;
            step();
            cyc++;
            if (acc) t++;
        end
        if (t < ROUNDS) check("expand_timeout", 32'(t), 32'(ROUNDS));
        if (!hold_start) start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_wt_valid", 32'(wt_valid), 32'd0);
        check("done_msg_ready", 32'(msg_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        step();
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_msg_ready", 32'(msg_ready), 32'd0);
        check("idle_wt_valid", 32'(wt_valid), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        msg_valid = 1'b0;
        msg_word  = 32'h0;
        wt_ready  = 1'b0;
        repeat (3) step();
        check("rst_wt_valid", 32'(wt_valid), 32'd0);
        check("rst_msg_ready", 32'(msg_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wt", wt, 32'd0);
        check("rst_wt_index", 32'(wt_index), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        // "abc" block, no stalls
        load_abc();
        run_block(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("abc_w0", obs_w[0], 32'h61626380);
        check("abc_w15", obs_w[15], 32'h00000018);
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000F0000);

        // load gaps
        load_abc();
        run_block(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("gap_w17", obs_w[17], 32'h000F0000);

        // backpressure
        load_random();
        run_block(1'b0, 1'b1, 1'b0, 1'b0, -1);

        // reset mid-expand, then a clean "abc" run
        load_random();
        run_block(1'b0, 1'b1, 1'b0, 1'b0, 30);
        load_abc();
        run_block(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("after_abort_w16", obs_w[16], 32'h61626380);
        check("after_abort_w17", obs_w[17], 32'h000F0000);

        // start pulsed mid-block, then start held across back-to-back blocks
        load_random();
        run_block(1'b1, 1'b1, 1'b1, 1'b0, -1);
        load_random();
        run_block(1'b0, 1'b0, 1'b0, 1'b1, -1);
        load_random();
        run_block(1'b1, 1'b1, 1'b0, 1'b1, -1);
        load_random();
        run_block(1'b0, 1'b0, 1'b0, 1'b0, -1);

        // random blocks
        for (int b = 0; b < 100; b++) begin
            load_random();
            run_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
